l4_header_parser: RTL and testbench
===================================

// Module: l4_header_parser
// PURPOSE
// Parametrised L4 header parser. Extracts TCP, UDP and ICMP headers from the byte stream that follows the IPv4 header.
// Skips TCP options using data offset. Flags truncated and malformed headers. Presents one result per packet on a valid/ready output.
// Sits after the IPv4 parser in the PL dataplane and feeds the flow classifier.
// PARAMETERS
// DATA_WIDTH  64  stream width in bits; multiple of 8, 8..512. BYTES = DATA_WIDTH/8 (localparam)
// PARSE_ICMP  1   1: parse ICMP (proto 1); 0: ICMP reported as unsupported
// PORTS
// clk              in   1             clock
// rst              in   1             asynchronous reset, active-high
// s_tdata          in   DATA_WIDTH    L4 bytes; lane k = bits [k*8+:8]; lane 0 first on the wire
// s_nbytes         in   $clog2(BYTES+1)  valid lanes this beat (lanes 0..n-1); 0 = no bytes
// s_tvalid         in   1             beat valid
// s_tlast          in   1             last beat of packet
// ip_hdr_done      in   1             IPv4 header consumed; beats are L4 bytes while high
// ip_protocol      in   8             IPv4 protocol field
// l4_valid         out  1             result valid; held until l4_ready
// l4_ready         in   1             result consumed
// l4_proto         out  2             l4_proto_e: NONE/TCP/UDP/ICMP
// src_port,dst_port out 16 each       TCP/UDP ports
// udp_length       out  16            UDP length
// l4_checksum      out  16            TCP/UDP/ICMP checksum
// tcp_seq,tcp_ack  out  32 each       sequence / ack numbers
// tcp_data_offset  out  4             header length in 32-bit words
// tcp_flags        out  8             CWR,ECE,URG,ACK,PSH,RST,SYN,FIN (bit7..0)
// tcp_window,tcp_urgent out 16 each   window size, urgent pointer
// icmp_type,icmp_code out 8 each      ICMP type/code
// l4_hdr_len       out  6             header bytes incl. TCP options (payload start)
// err_trunc        out  1             s_tlast before header complete
// err_bad_offset   out  1             TCP data offset < 5
// err_unsupported  out  1             protocol not TCP/UDP/(ICMP)
// err_overrun      out  1             1-cycle pulse: new result replaced one not yet consumed
// BEHAVIOUR
// - Reset: all outputs 0, l4_proto=NONE, state IDLE, byte counter 0.
// - Reset mid-packet aborts the packet. Parsing resumes at the next beat with ip_hdr_done=1 after rst deasserts.
// - Beat accepted when s_tvalid && ip_hdr_done. Lane k carries header byte offset cnt+k. cnt advances by s_nbytes. Counter is 6 bits and saturates at 63.
// - ip_protocol is sampled on the first accepted beat and held for the packet.
// - FSM IDLE: first accepted beat. Protocol supported -> PARSE. Otherwise post result with err_unsupported -> DRAIN.
// - FSM PARSE: capture fields by offset, big-endian.
//   - TCP: 0-19 per RFC793; byte 12 [7:4]=offset; byte 13 = flags.
//   - UDP: 0-7. ICMP: 0 type, 1 code, 2-3 checksum; 4-7 ignored.
//   - Header length = 20 (bad offset: 20, err_bad_offset=1) or offset*4 TCP; 8 UDP/ICMP. Option bytes are discarded.
//   - When cnt+s_nbytes >= header length: post result -> DRAIN, or -> IDLE if s_tlast.
//   - s_tlast first: post result with err_trunc=1, partial fields -> IDLE.
// - FSM DRAIN: ignore bytes until s_tlast -> IDLE.
// - s_tlast in any state: next state IDLE, cnt=0.
// - Bytes beyond header length in the completing beat are ignored.
// - Post result: output regs load from the shadow regs on the clock edge after the completing beat (latency 1). l4_valid=1.
//   - Shadow regs load for every header byte in the same cycle, so a completing beat's bytes are included.
// - l4_valid drops the cycle after l4_valid && l4_ready.
// - Post while l4_valid && !l4_ready: overwrite, l4_valid stays 1, err_overrun pulses 1 cycle.
// - Post coinciding with a ready handshake: new result loads, l4_valid stays 1, no overrun.
// - Fields not belonging to l4_proto read 0.
// STRUCTURE
// - Package l4_parser_pkg:
//   - l4_proto_e.
//   - IP_PROTO_TCP=6, IP_PROTO_UDP=17, IP_PROTO_ICMP=1, TCP_MIN_HDR=20, UDP_HDR_LEN=8, ICMP_HDR_LEN=8.
//   - Struct l4_hdr_t for shadow/output registers.
// - Sub-module l4_lane_decoder, one instance per lane (generate):
//   - Input: offset, byte, proto.
//   - Output: field select and byte position for the shadow-register write.
// - Top: FSM, counter, shadow/output regs, handshake.
// TESTING
// - DATA_WIDTH=64, UDP 2 beats:
//   - Header 1F90_0035_001C_ABCD, nbytes 8/4, tlast on 2nd.
//   - Expect l4_valid 1 cycle after beat 1: src=8080, dst=53, len=28, csum=ABCD.
// - TCP with offset 8 (32 B, 12 option bytes), flags 0x12:
//   - Expect l4_hdr_len=32, tcp_flags=0x12, seq/ack correct, options not captured.
//   - Repeat at DATA_WIDTH=8 and 128.
// - TCP tlast after 14 bytes:
//   - Expect err_trunc=1, ports/seq correct, l4_valid next cycle.
//   - Next packet parses cleanly.
// - ip_protocol=47 (GRE):
//   - Expect err_unsupported=1 on the first beat, l4_proto=NONE, beats ignored until tlast.
// - Two short UDP packets back-to-back, l4_ready=0:
//   - Expect err_overrun pulse, second packet's ports held.
//   - Then assert l4_ready: l4_valid drops next cycle.
// - Assert rst mid-TCP header (byte 10):
//   - All outputs 0. Following UDP packet parses correctly from offset 0.

Source files
------------

// File: rtl/l4_header_parser_pkg.sv
// Shared types and constants for the L4 header parser.
package l4_parser_pkg;

    typedef enum logic [1:0] {
        L4_NONE = 2'd0,
        L4_TCP  = 2'd1,
        L4_UDP  = 2'd2,
        L4_ICMP = 2'd3
    } l4_proto_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PARSE = 2'd1,
        S_DRAIN = 2'd2
    } parser_state_e;

    // Which header field a single byte lane writes into
    typedef enum logic [3:0] {
        F_NONE, F_SRC, F_DST, F_ULEN, F_CSUM, F_SEQ, F_ACK, F_DOFF,
        F_FLAGS, F_WIN, F_URG, F_ITYPE, F_ICODE
    } l4_field_e;

    localparam logic [7:0] IP_PROTO_TCP  = 8'd6;
    localparam logic [7:0] IP_PROTO_UDP  = 8'd17;
    localparam logic [7:0] IP_PROTO_ICMP = 8'd1;
    localparam logic [5:0] TCP_MIN_HDR   = 6'd20;
    localparam logic [5:0] UDP_HDR_LEN   = 6'd8;
    localparam logic [5:0] ICMP_HDR_LEN  = 6'd8;

    typedef struct packed {
        l4_proto_e   proto;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] udp_length;
        logic [15:0] checksum;
        logic [31:0] tcp_seq;
        logic [31:0] tcp_ack;
        logic [3:0]  tcp_data_offset;
        logic [7:0]  tcp_flags;
        logic [15:0] tcp_window;
        logic [15:0] tcp_urgent;
        logic [7:0]  icmp_type;
        logic [7:0]  icmp_code;
        logic [5:0]  hdr_len;
        logic        err_trunc;
        logic        err_bad_offset;
        logic        err_unsupported;
    } l4_hdr_t;

    // Map the IPv4 protocol number onto the protocols this parser understands
    function automatic l4_proto_e l4_proto_map(input logic [7:0] ip_proto, input logic parse_icmp);
        if (ip_proto == IP_PROTO_TCP) return L4_TCP;
        if (ip_proto == IP_PROTO_UDP) return L4_UDP;
        if (ip_proto == IP_PROTO_ICMP && parse_icmp) return L4_ICMP;
        return L4_NONE;
    endfunction

endpackage

// File: rtl/l4_header_parser_if.sv
// Stream-in / result-out bundle of the L4 header parser.
interface l4_header_parser_if #(parameter int DATA_WIDTH = 64);
    import l4_parser_pkg::*;
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int NB_W  = $clog2(BYTES + 1);

    logic [DATA_WIDTH-1:0] s_tdata;
    logic [NB_W-1:0]       s_nbytes;
    logic                  s_tvalid;
    logic                  s_tlast;
    logic                  ip_hdr_done;
    logic [7:0]            ip_protocol;
    logic                  l4_valid;
    logic                  l4_ready;
    l4_proto_e             l4_proto;
    logic [15:0]           src_port, dst_port, udp_length, l4_checksum;
    logic [31:0]           tcp_seq, tcp_ack;
    logic [3:0]            tcp_data_offset;
    logic [7:0]            tcp_flags;
    logic [15:0]           tcp_window, tcp_urgent;
    logic [7:0]            icmp_type, icmp_code;
    logic [5:0]            l4_hdr_len;
    logic                  err_trunc, err_bad_offset, err_unsupported, err_overrun;

    modport slave (
        input  s_tdata, s_nbytes, s_tvalid, s_tlast, ip_hdr_done, ip_protocol, l4_ready,
        output l4_valid, l4_proto, src_port, dst_port, udp_length, l4_checksum, tcp_seq, tcp_ack,
               tcp_data_offset, tcp_flags, tcp_window, tcp_urgent, icmp_type, icmp_code,
               l4_hdr_len, err_trunc, err_bad_offset, err_unsupported, err_overrun
    );

    modport master (
        output s_tdata, s_nbytes, s_tvalid, s_tlast, ip_hdr_done, ip_protocol, l4_ready,
        input  l4_valid, l4_proto, src_port, dst_port, udp_length, l4_checksum, tcp_seq, tcp_ack,
               tcp_data_offset, tcp_flags, tcp_window, tcp_urgent, icmp_type, icmp_code,
               l4_hdr_len, err_trunc, err_bad_offset, err_unsupported, err_overrun
    );
endinterface

// File: rtl/l4_header_parser_lane_decoder.sv
// Per-lane decode: header byte offset + protocol -> target field and byte position.
// pos counts bytes from the field LSB, so big-endian offsets map to descending pos.
module l4_lane_decoder import l4_parser_pkg::*; #(
    parameter int OFF_W = 7
) (
    input  logic [OFF_W-1:0] offset,
    input  logic [7:0]       data,
    input  l4_proto_e        proto,
    output l4_field_e        sel,
    output logic [1:0]       pos,
    output logic [7:0]       wbyte
);
    logic [4:0] o;

    // Offsets past 19 never map to a field, which discards TCP options and payload
    always_comb begin
        sel   = F_NONE;
        pos   = 2'd0;
        wbyte = data;
        o     = offset[4:0];
        if (offset < OFF_W'(20)) begin
            case (proto)
                L4_TCP: begin
                    pos = {1'b0, ~o[0]};
                    case (o)
                        5'd0, 5'd1:             sel = F_SRC;
                        5'd2, 5'd3:             sel = F_DST;
                        5'd4, 5'd5, 5'd6, 5'd7: begin sel = F_SEQ; pos = ~o[1:0]; end
                        5'd8, 5'd9, 5'd10, 5'd11: begin sel = F_ACK; pos = ~o[1:0]; end
                        5'd12:                  begin sel = F_DOFF; wbyte = {4'h0, data[7:4]}; end
                        5'd13:                  sel = F_FLAGS;
                        5'd14, 5'd15:           sel = F_WIN;
                        5'd16, 5'd17:           sel = F_CSUM;
                        5'd18, 5'd19:           sel = F_URG;
                        default:                sel = F_NONE;
                    endcase
                end
                L4_UDP: begin
                    pos = {1'b0, ~o[0]};
                    case (o)
                        5'd0, 5'd1: sel = F_SRC;
                        5'd2, 5'd3: sel = F_DST;
                        5'd4, 5'd5: sel = F_ULEN;
                        5'd6, 5'd7: sel = F_CSUM;
                        default:    sel = F_NONE;
                    endcase
                end
                L4_ICMP: begin
                    pos = {1'b0, ~o[0]};
                    case (o)
                        5'd0:       sel = F_ITYPE;
                        5'd1:       sel = F_ICODE;
                        5'd2, 5'd3: sel = F_CSUM;
                        default:    sel = F_NONE;
                    endcase
                end
                default: sel = F_NONE;
            endcase
        end
    end
endmodule

// File: rtl/l4_header_parser.sv
// L4 header parser: extracts TCP/UDP/ICMP headers after the IPv4 header and
// presents one result per packet on a valid/ready output.
module l4_header_parser import l4_parser_pkg::*; #(
    parameter int DATA_WIDTH = 64,
    parameter bit PARSE_ICMP = 1'b1
) (
    input logic               clk,
    input logic               rst,
    l4_header_parser_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int NB_W  = $clog2(BYTES + 1);
    localparam int OFF_W = $clog2(64 + BYTES);

    parser_state_e    state, state_n;
    logic [5:0]       cnt, cnt_n, hdr_len_c;
    logic [OFF_W-1:0] cnt_sum;
    l4_hdr_t          sh, sh_n, res, res_n;
    l4_proto_e        proto_cur;
    logic             acc, done, post, l4_valid_q, overrun_q;

    l4_field_e  lane_sel  [BYTES];
    logic [1:0] lane_pos  [BYTES];
    logic [7:0] lane_byte [BYTES];

    assign acc = bus.s_tvalid && bus.ip_hdr_done;
    // First beat takes the protocol straight off the input; later beats use the held copy
    assign proto_cur = (state == S_IDLE) ? l4_proto_map(bus.ip_protocol, PARSE_ICMP) : sh.proto;

    for (genvar k = 0; k < BYTES; k++) begin : g_lane
        l4_lane_decoder #(.OFF_W(OFF_W)) u_dec (
            .offset (OFF_W'(cnt) + OFF_W'(k)),
            .data   (bus.s_tdata[k*8 +: 8]),
            .proto  (proto_cur),
            .sel    (lane_sel[k]),
            .pos    (lane_pos[k]),
            .wbyte  (lane_byte[k])
        );
    end

    // Merge this beat's valid header bytes into the shadow; a new packet starts from zero
    always_comb begin
        sh_n       = (state == S_IDLE) ? '0 : sh;
        sh_n.proto = proto_cur;
        for (int k = 0; k < BYTES; k++) begin
            if (NB_W'(k) < bus.s_nbytes) begin
                case (lane_sel[k])
                    F_SRC:   sh_n.src_port[{lane_pos[k][0], 3'b000} +: 8]   = lane_byte[k];
                    F_DST:   sh_n.dst_port[{lane_pos[k][0], 3'b000} +: 8]   = lane_byte[k];
                    F_ULEN:  sh_n.udp_length[{lane_pos[k][0], 3'b000} +: 8] = lane_byte[k];
                    F_CSUM:  sh_n.checksum[{lane_pos[k][0], 3'b000} +: 8]   = lane_byte[k];
                    F_WIN:   sh_n.tcp_window[{lane_pos[k][0], 3'b000} +: 8] = lane_byte[k];
                    F_URG:   sh_n.tcp_urgent[{lane_pos[k][0], 3'b000} +: 8] = lane_byte[k];
                    F_SEQ:   sh_n.tcp_seq[{lane_pos[k], 3'b000} +: 8]       = lane_byte[k];
                    F_ACK:   sh_n.tcp_ack[{lane_pos[k], 3'b000} +: 8]       = lane_byte[k];
                    F_DOFF:  sh_n.tcp_data_offset = lane_byte[k][3:0];
                    F_FLAGS: sh_n.tcp_flags = lane_byte[k];
                    F_ITYPE: sh_n.icmp_type = lane_byte[k];
                    F_ICODE: sh_n.icmp_code = lane_byte[k];
                    default: ;
                endcase
            end
        end
    end

    // Header length uses the merged data offset, so a beat carrying byte 12 can also complete
    always_comb begin
        if (sh_n.proto == L4_TCP)
            hdr_len_c = (sh_n.tcp_data_offset >= 4'd5) ? {sh_n.tcp_data_offset, 2'b00} : TCP_MIN_HDR;
        else if (sh_n.proto == L4_UDP)
            hdr_len_c = UDP_HDR_LEN;
        else
            hdr_len_c = ICMP_HDR_LEN;
    end

    assign cnt_sum = OFF_W'(cnt) + OFF_W'(bus.s_nbytes);
    assign done    = cnt_sum >= OFF_W'(hdr_len_c);

    // Next state, byte counter and the result to post
    always_comb begin
        state_n              = state;
        cnt_n                = cnt;
        post                 = 1'b0;
        res_n                = sh_n;
        res_n.hdr_len        = hdr_len_c;
        res_n.err_trunc      = 1'b0;
        res_n.err_unsupported = 1'b0;
        // Offset is only judged once byte 12 has actually been seen
        res_n.err_bad_offset = (sh_n.proto == L4_TCP) && (cnt_sum > OFF_W'(12)) &&
                               (sh_n.tcp_data_offset < 4'd5);
        if (acc) begin
            cnt_n = (cnt_sum > OFF_W'(63)) ? 6'd63 : cnt_sum[5:0];
            case (state)
                S_IDLE, S_PARSE: begin
                    if (state == S_IDLE && proto_cur == L4_NONE) begin
                        post                  = 1'b1;
                        res_n                 = '0;
                        res_n.err_unsupported = 1'b1;
                        state_n               = S_DRAIN;
                    end else if (done) begin
                        post    = 1'b1;
                        state_n = S_DRAIN;
                    end else if (bus.s_tlast) begin
                        post            = 1'b1;
                        res_n.err_trunc = 1'b1;
                    end else begin
                        state_n = S_PARSE;
                    end
                end
                default: ;
            endcase
            if (bus.s_tlast) begin
                state_n = S_IDLE;
                cnt_n   = 6'd0;
            end
        end
    end

    // Parser state, byte counter and shadow header
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 6'd0;
            sh    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (acc && state != S_DRAIN) sh <= sh_n;
        end
    end

    // Result registers and valid/ready handshake; overwrite of an unconsumed result flags overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res        <= '0;
            l4_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (post) begin
                res        <= res_n;
                l4_valid_q <= 1'b1;
                overrun_q  <= l4_valid_q && !bus.l4_ready;
            end else if (bus.l4_ready) begin
                l4_valid_q <= 1'b0;
            end
        end
    end

    assign bus.l4_valid        = l4_valid_q;
    assign bus.err_overrun     = overrun_q;
    assign bus.l4_proto        = res.proto;
    assign bus.src_port        = res.src_port;
    assign bus.dst_port        = res.dst_port;
    assign bus.udp_length      = res.udp_length;
    assign bus.l4_checksum     = res.checksum;
    assign bus.tcp_seq         = res.tcp_seq;
    assign bus.tcp_ack         = res.tcp_ack;
    assign bus.tcp_data_offset = res.tcp_data_offset;
    assign bus.tcp_flags       = res.tcp_flags;
    assign bus.tcp_window      = res.tcp_window;
    assign bus.tcp_urgent      = res.tcp_urgent;
    assign bus.icmp_type       = res.icmp_type;
    assign bus.icmp_code       = res.icmp_code;
    assign bus.l4_hdr_len      = res.hdr_len;
    assign bus.err_trunc       = res.err_trunc;
    assign bus.err_bad_offset  = res.err_bad_offset;
    assign bus.err_unsupported = res.err_unsupported;

endmodule

// File: tb/tb_l4_header_parser.sv
// Directed bench for l4_header_parser at 8/64/128-bit stream widths.
module tb_l4_header_parser;
    logic         clk, rst;
    logic [127:0] d;
    logic [4:0]   nb;
    logic         vld, tlast, hdr_done, rdy;
    logic [7:0]   proto;
    int           w;
    int           n_chk, n_fail;
    logic [7:0]   pkt[$];

    l4_header_parser_if #(.DATA_WIDTH(8))   b8();
    l4_header_parser_if #(.DATA_WIDTH(64))  b64();
    l4_header_parser_if #(.DATA_WIDTH(128)) b128();

    assign b8.s_tdata     = d[7:0];
    assign b8.s_nbytes    = nb[0:0];
    assign b8.s_tvalid    = vld && (w == 8);
    assign b8.s_tlast     = tlast;
    assign b8.ip_hdr_done = hdr_done;
    assign b8.ip_protocol = proto;
    assign b8.l4_ready    = rdy;

    assign b64.s_tdata     = d[63:0];
    assign b64.s_nbytes    = nb[3:0];
    assign b64.s_tvalid    = vld && (w == 64);
    assign b64.s_tlast     = tlast;
    assign b64.ip_hdr_done = hdr_done;
    assign b64.ip_protocol = proto;
    assign b64.l4_ready    = rdy;

    assign b128.s_tdata     = d;
    assign b128.s_nbytes    = nb;
    assign b128.s_tvalid    = vld && (w == 128);
    assign b128.s_tlast     = tlast;
    assign b128.ip_hdr_done = hdr_done;
    assign b128.ip_protocol = proto;
    assign b128.l4_ready    = rdy;

    l4_header_parser #(.DATA_WIDTH(8),   .PARSE_ICMP(1'b1)) dut8   (.clk(clk), .rst(rst), .bus(b8));
    l4_header_parser #(.DATA_WIDTH(64),  .PARSE_ICMP(1'b1)) dut64  (.clk(clk), .rst(rst), .bus(b64));
    l4_header_parser #(.DATA_WIDTH(128), .PARSE_ICMP(1'b1)) dut128 (.clk(clk), .rst(rst), .bus(b128));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack(input int s, input int n);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[k*8 +: 8] = pkt[s+k];
        return r;
    endfunction

    task automatic beat(input logic [127:0] data, input int n, input bit last);
        d = data; nb = 5'(n); vld = 1'b1; tlast = last;
        @(posedge clk); #1;
        vld = 1'b0; tlast = 1'b0;
    endtask

    task automatic send(input int width, input logic [7:0] prot, input int len, input bit last);
        int bw;
        bw = width / 8; w = width; proto = prot;
        for (int i = 0; i < len; i += bw) begin
            int n;
            n = (len - i < bw) ? len - i : bw;
            beat(pack(i, n), n, last && (i + n >= len));
        end
    endtask

    task automatic consume();
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
    endtask

    task automatic mk_udp(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] ln,
                          input logic [15:0] cs);
        pkt = '{sp[15:8], sp[7:0], dp[15:8], dp[7:0], ln[15:8], ln[7:0], cs[15:8], cs[7:0]};
    endtask

    task automatic mk_tcp(input logic [3:0] doff, input int opt_n, input int pay_n);
        pkt = '{8'h04, 8'hD2, 8'h00, 8'h50, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                8'h77, 8'h88, {doff, 4'h0}, 8'h12, 8'hFA, 8'hF0, 8'h13, 8'h57, 8'h24, 8'h68};
        repeat (opt_n) pkt.push_back(8'hEE);
        repeat (pay_n) pkt.push_back(8'h99);
    endtask

    task automatic chk_tcp(input string t, input logic v, input logic [15:0] sp, input logic [15:0] dp,
                           input logic [31:0] sq, input logic [31:0] ak, input logic [7:0] fl,
                           input logic [5:0] hl, input logic [3:0] dof, input logic [15:0] cs,
                           input logic [15:0] ur, input logic [15:0] ul);
        chk({t, "_valid"}, 32'(v), 32'd1);
        chk({t, "_src"}, 32'(sp), 32'h04D2);
        chk({t, "_dst"}, 32'(dp), 32'h0050);
        chk({t, "_seq"}, sq, 32'h11223344);
        chk({t, "_ack"}, ak, 32'h55667788);
        chk({t, "_flags"}, 32'(fl), 32'h12);
        chk({t, "_hlen"}, 32'(hl), 32'd32);
        chk({t, "_doff"}, 32'(dof), 32'd8);
        chk({t, "_csum"}, 32'(cs), 32'h1357);
        chk({t, "_urg"}, 32'(ur), 32'h2468);
        chk({t, "_ulen"}, 32'(ul), 32'h0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; d = '0; nb = '0; vld = 1'b0; tlast = 1'b0; hdr_done = 1'b0;
        rdy = 1'b0; proto = 8'd0; w = 64;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(b64.l4_valid), 32'd0);
        chk("rst_proto", 32'(b64.l4_proto), 32'd0);
        chk("rst_src", 32'(b64.src_port), 32'd0);
        rst = 1'b0;
        hdr_done = 1'b1;
        @(posedge clk); #1;

        // UDP over two beats; result one cycle after the first
        mk_udp(16'h1F90, 16'h0035, 16'h001C, 16'hABCD);
        pkt.push_back(8'hDE); pkt.push_back(8'hAD); pkt.push_back(8'hBE); pkt.push_back(8'hEF);
        w = 64; proto = 8'd17;
        beat(pack(0, 8), 8, 1'b0);
        chk("udp_valid", 32'(b64.l4_valid), 32'd1);
        chk("udp_proto", 32'(b64.l4_proto), 32'd2);
        chk("udp_src", 32'(b64.src_port), 32'd8080);
        chk("udp_dst", 32'(b64.dst_port), 32'd53);
        chk("udp_len", 32'(b64.udp_length), 32'd28);
        chk("udp_csum", 32'(b64.l4_checksum), 32'hABCD);
        chk("udp_hlen", 32'(b64.l4_hdr_len), 32'd8);
        chk("udp_seq", b64.tcp_seq, 32'd0);
        beat(pack(8, 4), 4, 1'b1);
        chk("udp_tail_ovr", 32'(b64.err_overrun), 32'd0);
        chk("udp_tail_src", 32'(b64.src_port), 32'd8080);
        consume();

        // TCP with 12 option bytes at three widths
        mk_tcp(4'd8, 12, 4);
        send(64, 8'd6, 36, 1'b1);
        chk_tcp("tcp64", b64.l4_valid, b64.src_port, b64.dst_port, b64.tcp_seq, b64.tcp_ack,
                b64.tcp_flags, b64.l4_hdr_len, b64.tcp_data_offset, b64.l4_checksum,
                b64.tcp_urgent, b64.udp_length);
        chk("tcp64_proto", 32'(b64.l4_proto), 32'd1);
        chk("tcp64_win", 32'(b64.tcp_window), 32'hFAF0);
        consume();
        send(8, 8'd6, 36, 1'b1);
        chk_tcp("tcp8", b8.l4_valid, b8.src_port, b8.dst_port, b8.tcp_seq, b8.tcp_ack,
                b8.tcp_flags, b8.l4_hdr_len, b8.tcp_data_offset, b8.l4_checksum,
                b8.tcp_urgent, b8.udp_length);
        send(128, 8'd6, 36, 1'b1);
        chk_tcp("tcp128", b128.l4_valid, b128.src_port, b128.dst_port, b128.tcp_seq, b128.tcp_ack,
                b128.tcp_flags, b128.l4_hdr_len, b128.tcp_data_offset, b128.l4_checksum,
                b128.tcp_urgent, b128.udp_length);
        consume();

        // TCP cut short after 14 bytes, then a clean packet
        mk_tcp(4'd8, 12, 4);
        send(64, 8'd6, 14, 1'b1);
        chk("trunc_valid", 32'(b64.l4_valid), 32'd1);
        chk("trunc_err", 32'(b64.err_trunc), 32'd1);
        chk("trunc_src", 32'(b64.src_port), 32'h04D2);
        chk("trunc_dst", 32'(b64.dst_port), 32'h0050);
        chk("trunc_seq", b64.tcp_seq, 32'h11223344);
        chk("trunc_win", 32'(b64.tcp_window), 32'h0);
        consume();
        send(64, 8'd6, 36, 1'b1);
        chk("clean_trunc", 32'(b64.err_trunc), 32'd0);
        chk("clean_ack", b64.tcp_ack, 32'h55667788);
        chk("clean_hlen", 32'(b64.l4_hdr_len), 32'd32);
        consume();

        // Data offset below minimum: treated as 20 bytes and flagged
        mk_tcp(4'd3, 0, 4);
        send(64, 8'd6, 24, 1'b1);
        chk("badoff_err", 32'(b64.err_bad_offset), 32'd1);
        chk("badoff_hlen", 32'(b64.l4_hdr_len), 32'd20);
        chk("badoff_doff", 32'(b64.tcp_data_offset), 32'd3);
        chk("badoff_urg", 32'(b64.tcp_urgent), 32'h2468);
        consume();

        // GRE: reported unsupported on the first beat, rest ignored
        mk_tcp(4'd5, 0, 0);
        w = 64; proto = 8'd47;
        beat(pack(0, 8), 8, 1'b0);
        chk("gre_valid", 32'(b64.l4_valid), 32'd1);
        chk("gre_unsup", 32'(b64.err_unsupported), 32'd1);
        chk("gre_proto", 32'(b64.l4_proto), 32'd0);
        chk("gre_src", 32'(b64.src_port), 32'd0);
        rdy = 1'b1;
        beat(pack(8, 8), 8, 1'b1);
        rdy = 1'b0;
        chk("gre_drain_valid", 32'(b64.l4_valid), 32'd0);

        // Back-to-back results with nobody consuming
        mk_udp(16'h1111, 16'h2222, 16'h0008, 16'h0000);
        send(64, 8'd17, 8, 1'b1);
        chk("ovr_first_ovr", 32'(b64.err_overrun), 32'd0);
        mk_udp(16'h3333, 16'h4444, 16'h0008, 16'h0000);
        send(64, 8'd17, 8, 1'b1);
        chk("ovr_pulse", 32'(b64.err_overrun), 32'd1);
        chk("ovr_valid", 32'(b64.l4_valid), 32'd1);
        chk("ovr_src", 32'(b64.src_port), 32'h3333);
        chk("ovr_dst", 32'(b64.dst_port), 32'h4444);
        @(posedge clk); #1;
        chk("ovr_pulse_end", 32'(b64.err_overrun), 32'd0);
        chk("ovr_hold_valid", 32'(b64.l4_valid), 32'd1);
        consume();
        chk("ready_drop", 32'(b64.l4_valid), 32'd0);

        // Reset while 10 bytes into a TCP header
        mk_tcp(4'd5, 0, 4);
        send(64, 8'd6, 10, 1'b0);
        rst = 1'b1;
        #2;
        chk("midrst_valid", 32'(b64.l4_valid), 32'd0);
        chk("midrst_src", 32'(b64.src_port), 32'd0);
        chk("midrst_dst", 32'(b64.dst_port), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        mk_udp(16'h1F90, 16'h0035, 16'h001C, 16'hABCD);
        pkt.push_back(8'h01); pkt.push_back(8'h02); pkt.push_back(8'h03); pkt.push_back(8'h04);
        send(64, 8'd17, 12, 1'b1);
        chk("post_rst_proto", 32'(b64.l4_proto), 32'd2);
        chk("post_rst_src", 32'(b64.src_port), 32'd8080);
        chk("post_rst_len", 32'(b64.udp_length), 32'd28);
        chk("post_rst_csum", 32'(b64.l4_checksum), 32'hABCD);
        chk("post_rst_seq", b64.tcp_seq, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
